mpu_load_arbiter: RTL and testbench
===================================

Name: mpu_load_arbiter

Overview:
- Shares the single matrix-load path (external source -> load unit -> register file) among NREQ external memory requesters.
- Grants one requester at a time, round-robin, and holds the grant for a whole m x n matrix transfer.
- Forwards elements, size and address to the load unit and returns per-requester ack, error and done.
- Rejects bad dimensions before the load unit ever sees them.

Parameters:
NREQ, 2, number of requesters (2..8)
GBITS, 0, grant index width minus 1 (set to clog2(NREQ)-1)
Element, size and address widths come from global_defs: FPBITS, MBITS, NBITS, MATRIX_REG_BITS. Limits M and N also come from global_defs.

Ports:
clk  in  1  clock
rst  in  1  reset
req_in  in  NREQ  per-requester load request; held through the whole transfer
req_element_in  in  NREQ x (FPBITS+1)  per-requester current matrix element
req_m_size_in  in  NREQ x (MBITS+1)  per-requester row count
req_n_size_in  in  NREQ x (NBITS+1)  per-requester column count
req_addr_in  in  NREQ x (MATRIX_REG_BITS+1)  per-requester destination matrix register
req_ack_out  out  NREQ  element accepted; requester advances to next element
req_error_out  out  NREQ  one-cycle error pulse
req_done_out  out  NREQ  one-cycle matrix-complete pulse
load_en_out  out  1  load-unit enable
load_element_out  out  FPBITS+1  element to load unit
load_m_size_out  out  MBITS+1  latched row count
load_n_size_out  out  NBITS+1  latched column count
load_addr_out  out  MATRIX_REG_BITS+1  latched register address
load_ack_in  in  1  load-unit element acknowledge
load_error_in  in  1  load-unit error
busy_out  out  1  a grant is active
grant_id_out  out  GBITS+1  index of granted requester; 0 when idle

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ARB_IDLE; count=0; latched size/addr=0; last_grant=NREQ-1, so requester 0 wins first.
  - All outputs 0. Reset mid-transfer aborts immediately; no done or error pulse.
- States: ARB_IDLE, ARB_STREAM, ARB_DONE.
- ARB_IDLE:
  - Scan req_in from last_grant+1, wrapping modulo NREQ. First asserted requester is candidate c.
  - Invalid dims (m=0, n=0, m>M or n>N): pulse req_error_out[c] next cycle; last_grant<=c; stay in IDLE. A persistent bad requester therefore cannot starve others.
  - Valid: latch c, m, n, addr; total<=m*n (width MBITS+NBITS+2, no overflow); count<=0; go to ARB_STREAM.
  - Grant latency: request seen in cycle t -> load_en_out=1 in cycle t+1.
- ARB_STREAM:
  - load_en_out=1, busy_out=1, grant_id_out=c.
  - load_element_out = req_element_in[c], combinational pass-through.
  - Sizes and addr come from the latched copies; requester size changes mid-stream are ignored.
  - req_ack_out[c]=load_ack_in, combinational; all other acks stay 0.
  - Each cycle with load_ack_in=1: count<=count+1. When count==total-1 and load_ack_in=1, go to ARB_DONE.
  - load_error_in=1: pulse req_error_out[c] next cycle, go to ARB_IDLE, last_grant<=c. Error takes priority over a simultaneous final ack.
  - req_in[c] dropped before completion: treated as abort. req_error_out[c] pulse, go to ARB_IDLE, last_grant<=c.
- ARB_DONE (exactly one cycle):
  - load_en_out=0; req_done_out[c]=1; last_grant<=c; busy_out=1; go to ARB_IDLE.
  - Guarantees at least 2 cycles with load_en_out=0 between matrices, which the load unit needs to clear its row/column pointers.
- Fairness: after requester k completes or errors, every other pending requester is served before k again.
- Only one of req_ack_out / req_error_out / req_done_out is ever nonzero for a given requester in a cycle.

Test Plan:
- Req0 only, 2x2, load-unit model acks every enabled cycle:
  - Expect load_en_out high exactly 4 cycles starting 1 cycle after req.
  - Expect req_ack_out[0] 4 pulses, then req_done_out[0] one cycle, busy_out low 1 cycle later.
- Req0 and req1 asserted together, both 1x3, held continuously:
  - Expect grant order 0,1,0,1.
  - Expect >=2 idle cycles of load_en_out between transfers.
  - Expect req_ack_out[1]=0 throughout any req0 grant.
- Req0 with m=0, n=3, plus req1 valid 2x1:
  - Expect req_error_out[0] one pulse, no load_en_out for req0.
  - Expect req1 granted on the following scan.
- Req0 at limit M x N (e.g. 8x8):
  - Expect exactly 64 acks, then done; load_m_size_out=8 held throughout.
- Req0 with (M+1) x 1: error pulse only, no grant.
- Mid-stream faults on a 3x3 transfer:
  - load_error_in at element 5 -> req_error_out pulse, back to idle, no done.
  - rst at element 5 -> all outputs 0 next cycle, req0 regranted from element 0 after release.
  - req_in[0] dropped at element 5 -> error pulse, no done.

Source files
------------

// File: rtl/mpu_load_arbiter_if.sv
// Bundle of the requester side and load-unit side signals of mpu_load_arbiter.
//   slave  : arbiter view (requests and load-unit handshake in, grants/data out)
//   master : environment view (requesters + load unit), directions reversed
// Width parameters mirror the global_defs values used by the arbiter.
interface mpu_load_arbiter_if #(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned GBITS           = 0,
  parameter int unsigned FPBITS          = 31,
  parameter int unsigned MBITS           = 3,
  parameter int unsigned NBITS           = 3,
  parameter int unsigned MATRIX_REG_BITS = 2
);
  logic [NREQ-1:0]                        req_in;
  logic [NREQ-1:0][FPBITS:0]              req_element_in;
  logic [NREQ-1:0][MBITS:0]               req_m_size_in;
  logic [NREQ-1:0][NBITS:0]               req_n_size_in;
  logic [NREQ-1:0][MATRIX_REG_BITS:0]     req_addr_in;
  logic [NREQ-1:0]                        req_ack_out;
  logic [NREQ-1:0]                        req_error_out;
  logic [NREQ-1:0]                        req_done_out;
  logic                                   load_en_out;
  logic [FPBITS:0]                        load_element_out;
  logic [MBITS:0]                         load_m_size_out;
  logic [NBITS:0]                         load_n_size_out;
  logic [MATRIX_REG_BITS:0]               load_addr_out;
  logic                                   load_ack_in;
  logic                                   load_error_in;
  logic                                   busy_out;
  logic [GBITS:0]                         grant_id_out;

  modport slave (
    input  req_in, req_element_in, req_m_size_in, req_n_size_in, req_addr_in,
    input  load_ack_in, load_error_in,
    output req_ack_out, req_error_out, req_done_out,
    output load_en_out, load_element_out, load_m_size_out, load_n_size_out, load_addr_out,
    output busy_out, grant_id_out
  );

  modport master (
    output req_in, req_element_in, req_m_size_in, req_n_size_in, req_addr_in,
    output load_ack_in, load_error_in,
    input  req_ack_out, req_error_out, req_done_out,
    input  load_en_out, load_element_out, load_m_size_out, load_n_size_out, load_addr_out,
    input  busy_out, grant_id_out
  );
endinterface

// File: rtl/mpu_load_arbiter.sv
// Round-robin arbiter sharing the matrix-load path among NREQ requesters.
// A grant is held for a whole m x n transfer; bad dimensions are rejected
// with an error pulse before the load unit is enabled.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mpu_load_arbiter_if.slave (requests, element/size/addr,
//              per-requester ack/error/done, load-unit enable/data/handshake,
//              busy and granted index)
// req_ack_out and load_element_out are combinational pass-throughs of the
// granted channel; every other output is registered.
module mpu_load_arbiter #(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned GBITS           = 0,
  parameter int unsigned FPBITS          = 31,
  parameter int unsigned MBITS           = 3,
  parameter int unsigned NBITS           = 3,
  parameter int unsigned MATRIX_REG_BITS = 2,
  parameter int unsigned M               = 8,
  parameter int unsigned N               = 8
) (
  input logic                clk,
  input logic                rst,
  mpu_load_arbiter_if.slave  bus
);

  localparam int unsigned GW = GBITS + 1;
  localparam int unsigned MW = MBITS + 1;
  localparam int unsigned NW = NBITS + 1;
  localparam int unsigned AW = MATRIX_REG_BITS + 1;
  localparam int unsigned TW = MBITS + NBITS + 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  arb_state_e       state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last_grant;
  logic [TW-1:0]    total;
  logic [TW-1:0]    count;
  logic [MW-1:0]    m_q;
  logic [NW-1:0]    n_q;
  logic [AW-1:0]    addr_q;
  logic             load_en_q;
  logic             busy_q;
  logic [GW-1:0]    grant_id_q;
  logic [NREQ-1:0]  error_q;
  logic [NREQ-1:0]  done_q;

  logic             cand_valid;
  logic [GW-1:0]    cand;
  logic [MW-1:0]    cand_m;
  logic [NW-1:0]    cand_n;
  logic             dims_bad;

  // Round-robin scan: descending offsets so the nearest one after last_grant wins.
  always_comb begin
    cand_valid = 1'b0;
    cand       = '0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      if (bus.req_in[GW'((int'(last_grant) + i) % int'(NREQ))]) begin
        cand_valid = 1'b1;
        cand       = GW'((int'(last_grant) + i) % int'(NREQ));
      end
    end
  end

  assign cand_m   = bus.req_m_size_in[cand];
  assign cand_n   = bus.req_n_size_in[cand];
  assign dims_bad = (cand_m == '0) || (cand_n == '0) ||
                    (cand_m > MW'(M)) || (cand_n > NW'(N));

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      total      <= '0;
      count      <= '0;
      m_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      load_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
      error_q    <= '0;
      done_q     <= '0;
    end else begin
      error_q <= '0;
      done_q  <= '0;
      case (state)
        ARB_IDLE: begin
          if (cand_valid) begin
            if (dims_bad) begin
              // Rejected requester moves to the back of the rotation.
              error_q[cand] <= 1'b1;
              last_grant    <= cand;
            end else begin
              grant      <= cand;
              m_q        <= cand_m;
              n_q        <= cand_n;
              addr_q     <= bus.req_addr_in[cand];
              total      <= TW'(cand_m) * TW'(cand_n);
              count      <= '0;
              load_en_q  <= 1'b1;
              busy_q     <= 1'b1;
              grant_id_q <= cand;
              state      <= ARB_STREAM;
            end
          end
        end
        ARB_STREAM: begin
          // Load-unit error or requester drop aborts; wins over a final ack.
          if (bus.load_error_in || !bus.req_in[grant]) begin
            error_q[grant] <= 1'b1;
            last_grant     <= grant;
            load_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            grant_id_q     <= '0;
            state          <= ARB_IDLE;
          end else if (bus.load_ack_in) begin
            count <= count + TW'(1);
            if (count == total - TW'(1)) begin
              load_en_q     <= 1'b0;
              done_q[grant] <= 1'b1;
              state         <= ARB_DONE;
            end
          end
        end
        ARB_DONE: begin
          // One dead cycle here plus the IDLE scan keeps load_en low for two cycles.
          last_grant <= grant;
          busy_q     <= 1'b0;
          grant_id_q <= '0;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Ack only the granted requester, and only while streaming.
  always_comb begin
    bus.req_ack_out = '0;
    if (state == ARB_STREAM) begin
      bus.req_ack_out[grant] = bus.load_ack_in;
    end
  end

  assign bus.load_element_out = (state == ARB_STREAM) ? bus.req_element_in[grant] : '0;
  assign bus.req_error_out    = error_q;
  assign bus.req_done_out     = done_q;
  assign bus.load_en_out      = load_en_q;
  assign bus.load_m_size_out  = m_q;
  assign bus.load_n_size_out  = n_q;
  assign bus.load_addr_out    = addr_q;
  assign bus.busy_out         = busy_q;
  assign bus.grant_id_out     = grant_id_q;

endmodule

// File: tb/tb_mpu_load_arbiter.sv
// Directed bench for mpu_load_arbiter: reset, single transfer, round-robin,
// dimension rejection, size limits and mid-stream aborts.
module tb_mpu_load_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned GBITS = 0;
  localparam int unsigned FPB   = 31;
  localparam int unsigned MB    = 3;
  localparam int unsigned NB    = 3;
  localparam int unsigned RB    = 2;

  logic clk = 1'b0;
  logic rst;
  logic ack_auto;
  int   total_n;
  int   bad_n;

  mpu_load_arbiter_if #(.NREQ(NREQ), .GBITS(GBITS), .FPBITS(FPB), .MBITS(MB),
                        .NBITS(NB), .MATRIX_REG_BITS(RB)) bus ();

  mpu_load_arbiter #(.NREQ(NREQ), .GBITS(GBITS), .FPBITS(FPB), .MBITS(MB),
                     .NBITS(NB), .MATRIX_REG_BITS(RB), .M(8), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Load-unit model: acknowledges every enabled cycle when ack_auto is set.
  assign bus.load_ack_in = ack_auto & bus.load_en_out;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_in = '0;
    bus.load_error_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input int m, input int n, input int a);
    bus.req_m_size_in[r] = 4'(m);
    bus.req_n_size_in[r] = 4'(n);
    bus.req_addr_in[r]   = 3'(a);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ack_auto = 1'b1;
    bus.load_error_in = 1'b0;
    set_req(0, 2, 2, 1);
    set_req(1, 2, 2, 2);
    bus.req_in = '1;
    tick();
    tick();
    total_n += 10;
    if (bus.load_en_out !== 1'b0) begin bad_n++; $display("FAIL reset_en got=%b exp=0", bus.load_en_out); end
    if (bus.busy_out !== 1'b0) begin bad_n++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
    if (bus.grant_id_out !== '0) begin bad_n++; $display("FAIL reset_gid got=%0d exp=0", bus.grant_id_out); end
    if (bus.req_ack_out !== '0) begin bad_n++; $display("FAIL reset_ack got=%b exp=0", bus.req_ack_out); end
    if (bus.req_error_out !== '0) begin bad_n++; $display("FAIL reset_err got=%b exp=0", bus.req_error_out); end
    if (bus.req_done_out !== '0) begin bad_n++; $display("FAIL reset_done got=%b exp=0", bus.req_done_out); end
    if (bus.load_m_size_out !== '0) begin bad_n++; $display("FAIL reset_m got=%0d exp=0", bus.load_m_size_out); end
    if (bus.load_n_size_out !== '0) begin bad_n++; $display("FAIL reset_n got=%0d exp=0", bus.load_n_size_out); end
    if (bus.load_addr_out !== '0) begin bad_n++; $display("FAIL reset_addr got=%0d exp=0", bus.load_addr_out); end
    if (bus.load_element_out !== '0) begin bad_n++; $display("FAIL reset_elem got=%h exp=0", bus.load_element_out); end
    bus.req_in = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp_en, exp_done, exp_busy;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 2, 2, 3);
    bus.req_in = 2'b01;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_en   = (k < 4);
      exp_done = (k == 4);
      exp_busy = (k <= 4);
      total_n += 5;
      if (bus.load_en_out !== exp_en) begin bad_n++; $display("FAIL single_en k=%0d got=%b exp=%b", k, bus.load_en_out, exp_en); end
      if (bus.req_ack_out[0] !== exp_en) begin bad_n++; $display("FAIL single_ack k=%0d got=%b exp=%b", k, bus.req_ack_out[0], exp_en); end
      if (bus.req_ack_out[1] !== 1'b0) begin bad_n++; $display("FAIL single_ack1 k=%0d got=%b exp=0", k, bus.req_ack_out[1]); end
      if (bus.req_done_out[0] !== exp_done) begin bad_n++; $display("FAIL single_done k=%0d got=%b exp=%b", k, bus.req_done_out[0], exp_done); end
      if (bus.busy_out !== exp_busy) begin bad_n++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy_out, exp_busy); end
      if (exp_en) begin
        total_n += 4;
        if (bus.load_m_size_out !== 4'd2) begin bad_n++; $display("FAIL single_m k=%0d got=%0d exp=2", k, bus.load_m_size_out); end
        if (bus.load_n_size_out !== 4'd2) begin bad_n++; $display("FAIL single_n k=%0d got=%0d exp=2", k, bus.load_n_size_out); end
        if (bus.load_addr_out !== 3'd3) begin bad_n++; $display("FAIL single_addr k=%0d got=%0d exp=3", k, bus.load_addr_out); end
        if (bus.load_element_out !== 32'hA5A5_0000) begin bad_n++; $display("FAIL single_elem k=%0d got=%h exp=a5a50000", k, bus.load_element_out); end
      end
      if (k == 4) bus.req_in = '0;
    end
  endtask

  task automatic test_round_robin();
    int   rise_k[$];
    int   rise_id[$];
    int   exp_id;
    int   gap;
    int   ack1_viol;
    logic prev_en;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 1, 3, 1);
    set_req(1, 1, 3, 2);
    bus.req_in = 2'b11;
    prev_en = 1'b0;
    ack1_viol = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (bus.load_en_out && !prev_en) begin
        rise_k.push_back(k);
        rise_id.push_back(int'(bus.grant_id_out));
      end
      if (bus.load_en_out && bus.grant_id_out == '0 && bus.req_ack_out[1]) ack1_viol++;
      prev_en = bus.load_en_out;
    end
    total_n += 2;
    if (ack1_viol != 0) begin bad_n++; $display("FAIL rr_ack1 got=%0d exp=0", ack1_viol); end
    if (rise_k.size() < 4) begin
      bad_n++; $display("FAIL rr_grants got=%0d exp>=4", rise_k.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_id = i % 2;
        total_n++;
        if (rise_id[i] != exp_id) begin bad_n++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, rise_id[i], exp_id); end
        if (i > 0) begin
          gap = rise_k[i] - (rise_k[i-1] + 3);
          total_n++;
          if (gap < 2) begin bad_n++; $display("FAIL rr_gap i=%0d got=%0d exp>=2", i, gap); end
        end
      end
    end
    apply_reset();
  endtask

  task automatic test_bad_dims();
    int err0_cnt, err0_k, first_k, first_id, en0, done1;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 0, 3, 1);
    set_req(1, 2, 1, 2);
    bus.req_in = 2'b11;
    err0_cnt = 0; err0_k = -1; first_k = -1; first_id = -1; en0 = 0; done1 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.req_error_out[0]) begin
        err0_cnt++;
        if (err0_k < 0) err0_k = k;
        bus.req_in[0] = 1'b0;
      end
      if (bus.load_en_out && bus.grant_id_out == '0) en0++;
      if (bus.load_en_out && first_k < 0) begin first_k = k; first_id = int'(bus.grant_id_out); end
      if (bus.req_done_out[1]) begin done1++; bus.req_in[1] = 1'b0; end
    end
    total_n += 6;
    if (err0_k != 0) begin bad_n++; $display("FAIL bad_err_time got=%0d exp=0", err0_k); end
    if (err0_cnt != 1) begin bad_n++; $display("FAIL bad_err_cnt got=%0d exp=1", err0_cnt); end
    if (en0 != 0) begin bad_n++; $display("FAIL bad_en0 got=%0d exp=0", en0); end
    if (first_k != 1) begin bad_n++; $display("FAIL bad_grant_time got=%0d exp=1", first_k); end
    if (first_id != 1) begin bad_n++; $display("FAIL bad_grant_id got=%0d exp=1", first_id); end
    if (done1 != 1) begin bad_n++; $display("FAIL bad_done1 got=%0d exp=1", done1); end
  endtask

  task automatic test_limit();
    int acks, done_k, sz_viol;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 8, 8, 5);
    bus.req_in = 2'b01;
    acks = 0; done_k = -1; sz_viol = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (bus.req_ack_out[0]) acks++;
      if (bus.load_en_out && (bus.load_m_size_out !== 4'd8 || bus.load_n_size_out !== 4'd8)) sz_viol++;
      if (bus.req_done_out[0] && done_k < 0) begin done_k = k; bus.req_in = '0; end
    end
    total_n += 3;
    if (acks != 64) begin bad_n++; $display("FAIL limit_acks got=%0d exp=64", acks); end
    if (done_k != 64) begin bad_n++; $display("FAIL limit_done got=%0d exp=64", done_k); end
    if (sz_viol != 0) begin bad_n++; $display("FAIL limit_size got=%0d exp=0", sz_viol); end
  endtask

  task automatic test_over_m();
    int err_cnt, err_k, en;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 9, 1, 0);
    bus.req_in = 2'b01;
    err_cnt = 0; err_k = -1; en = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.req_error_out[0]) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
        bus.req_in = '0;
      end
      if (bus.load_en_out) en++;
    end
    total_n += 3;
    if (err_k != 0) begin bad_n++; $display("FAIL overm_err_time got=%0d exp=0", err_k); end
    if (err_cnt != 1) begin bad_n++; $display("FAIL overm_err_cnt got=%0d exp=1", err_cnt); end
    if (en != 0) begin bad_n++; $display("FAIL overm_en got=%0d exp=0", en); end
  endtask

  task automatic test_mid_error();
    int done_cnt;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 3, 3, 1);
    bus.req_in = 2'b01;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.req_done_out[0]) done_cnt++;
      if (k == 6) begin
        total_n += 3;
        if (bus.req_error_out[0] !== 1'b1) begin bad_n++; $display("FAIL miderr_err got=%b exp=1", bus.req_error_out[0]); end
        if (bus.load_en_out !== 1'b0) begin bad_n++; $display("FAIL miderr_en got=%b exp=0", bus.load_en_out); end
        if (bus.busy_out !== 1'b0) begin bad_n++; $display("FAIL miderr_busy got=%b exp=0", bus.busy_out); end
        bus.load_error_in = 1'b0;
        bus.req_in = '0;
      end
      if (k == 5) bus.load_error_in = 1'b1;
    end
    total_n++;
    if (done_cnt != 0) begin bad_n++; $display("FAIL miderr_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_mid_reset();
    int acks, done_k;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 3, 3, 1);
    bus.req_in = 2'b01;
    acks = 0; done_k = -1;
    for (int k = 0; k < 21; k++) begin
      tick();
      if (k == 6) begin
        total_n += 6;
        if (bus.load_en_out !== 1'b0) begin bad_n++; $display("FAIL midrst_en got=%b exp=0", bus.load_en_out); end
        if (bus.busy_out !== 1'b0) begin bad_n++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_out); end
        if (bus.req_ack_out !== '0) begin bad_n++; $display("FAIL midrst_ack got=%b exp=0", bus.req_ack_out); end
        if (bus.req_error_out !== '0) begin bad_n++; $display("FAIL midrst_err got=%b exp=0", bus.req_error_out); end
        if (bus.req_done_out !== '0) begin bad_n++; $display("FAIL midrst_done got=%b exp=0", bus.req_done_out); end
        if (bus.load_m_size_out !== '0) begin bad_n++; $display("FAIL midrst_m got=%0d exp=0", bus.load_m_size_out); end
      end
      if (k == 7) begin
        total_n++;
        if (bus.load_en_out !== 1'b1) begin bad_n++; $display("FAIL midrst_regrant got=%b exp=1", bus.load_en_out); end
      end
      if (k >= 7 && bus.req_ack_out[0]) acks++;
      if (bus.req_done_out[0] && done_k < 0) begin done_k = k; bus.req_in = '0; end
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
    end
    total_n += 2;
    if (acks != 9) begin bad_n++; $display("FAIL midrst_acks got=%0d exp=9", acks); end
    if (done_k != 16) begin bad_n++; $display("FAIL midrst_done_time got=%0d exp=16", done_k); end
  endtask

  task automatic test_mid_drop();
    int done_cnt, err_cnt;
    apply_reset();
    ack_auto = 1'b1;
    set_req(0, 3, 3, 1);
    bus.req_in = 2'b01;
    done_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.req_done_out[0]) done_cnt++;
      if (bus.req_error_out[0]) err_cnt++;
      if (k == 6) begin
        total_n += 2;
        if (bus.req_error_out[0] !== 1'b1) begin bad_n++; $display("FAIL drop_err got=%b exp=1", bus.req_error_out[0]); end
        if (bus.load_en_out !== 1'b0) begin bad_n++; $display("FAIL drop_en got=%b exp=0", bus.load_en_out); end
      end
      if (k == 5) bus.req_in[0] = 1'b0;
    end
    total_n += 2;
    if (done_cnt != 0) begin bad_n++; $display("FAIL drop_done got=%0d exp=0", done_cnt); end
    if (err_cnt != 1) begin bad_n++; $display("FAIL drop_err_cnt got=%0d exp=1", err_cnt); end
  endtask

  initial begin
    total_n = 0;
    bad_n   = 0;
    rst = 1'b1;
    ack_auto = 1'b0;
    bus.req_in = '0;
    bus.load_error_in = 1'b0;
    bus.req_element_in[0] = 32'hA5A5_0000;
    bus.req_element_in[1] = 32'h5A5A_1111;
    bus.req_m_size_in = '0;
    bus.req_n_size_in = '0;
    bus.req_addr_in   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_bad_dims();
    test_limit();
    test_over_m();
    test_mid_error();
    test_mid_reset();
    test_mid_drop();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
